// File: rtl/alu_issue_ctrl_if.sv
// Instruction-memory fetch channel and ALU operand/result channel of the
// issue controller.
//   master : the sequencer (drives imem_req/imem_addr and ALU operands,
//            consumes instruction words and ALU results)
//   slave  : the memory/ALU side
// Signals:
//   imem_req/imem_addr            fetch request and address (PC)
//   imem_valid/imem_data          returned 16-bit instruction word
//   alu_a/alu_b/alu_opcode        ALU operands and opcode
//   alu_result/alu_zero/
//   alu_branch_taken              ALU outputs
interface alu_issue_ctrl_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_branch_taken;

  modport master (
    output imem_req, imem_addr, alu_a, alu_b, alu_opcode,
    input  imem_valid, imem_data, alu_result, alu_zero, alu_branch_taken
  );

  modport slave (
    input  imem_req, imem_addr, alu_a, alu_b, alu_opcode,
    output imem_valid, imem_data, alu_result, alu_zero, alu_branch_taken
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle instruction sequencer driving an 8-bit ALU.
// Fetches 16-bit instructions, reads operands from a 4x8 register file,
// issues them to the ALU and writes back the result / updates the PC.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             fetch + ALU channels (master side)
//   retire          one-cycle pulse during each EXECUTE
//   halted          set once HALT retires, held until reset
//   dbg_sel/dbg_data combinational debug read of register dbg_sel
module alu_issue_ctrl (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_ctrl_if.master        bus,
  output logic                    retire,
  output logic                    halted,
  input  logic [1:0]              dbg_sel,
  output logic [7:0]              dbg_data
);

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned NR = 4;

  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BNE  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED
  } state_t;

  state_t         state;
  logic [DW-1:0]  pc;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  regs [NR];

  // Instruction fields
  logic [3:0]     op_c;
  logic [1:0]     f_hi_c;
  logic [1:0]     f_mid_c;
  logic [1:0]     f_lo_c;
  logic [DW-1:0]  imm_c;

  assign op_c    = ir[15:12];
  assign f_hi_c  = ir[11:10];
  assign f_mid_c = ir[9:8];
  assign f_lo_c  = ir[7:6];
  assign imm_c   = ir[7:0];

  logic           is_write_c;
  logic           is_branch_c;
  logic           is_halt_c;
  logic [DW-1:0]  dec_a_c;
  logic [DW-1:0]  dec_b_c;
  logic [DW-1:0]  pc_inc_c;
  logic [DW-1:0]  pc_next_c;

  assign is_write_c  = (op_c <= OP_SLT) || (op_c == OP_ADDI);
  assign is_branch_c = (op_c == OP_BEQ) || (op_c == OP_BNE);
  assign is_halt_c   = (op_c == OP_HALT);

  // Operand selection; R-type field layout is the default for every opcode
  always_comb begin
    dec_a_c = regs[f_mid_c];
    dec_b_c = regs[f_lo_c];
    if (op_c == OP_ADDI) begin
      dec_b_c = imm_c;
    end else if (is_branch_c) begin
      dec_a_c = regs[f_hi_c];
      dec_b_c = regs[f_mid_c];
    end
  end

  // Adding the raw 8-bit offset mod 256 is the same as adding its sign extension
  assign pc_inc_c  = pc + DW'(1);
  assign pc_next_c = (is_branch_c && bus.alu_branch_taken) ? (pc_inc_c + imm_c) : pc_inc_c;

  assign dbg_data = regs[dbg_sel];

  // Sequencer: state, architectural state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= '0;
      ir             <= '0;
      for (int i = 0; i < int'(NR); i++) regs[i] <= '0;
      bus.imem_req   <= 1'b0;
      bus.imem_addr  <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      retire         <= 1'b0;
      halted         <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
          state         <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_valid) begin
            ir           <= bus.imem_data;
            bus.imem_req <= 1'b0;
            state        <= S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_a      <= dec_a_c;
          bus.alu_b      <= dec_b_c;
          bus.alu_opcode <= op_c;
          retire         <= 1'b1;
          state          <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_write_c) regs[f_hi_c] <= bus.alu_result;
          if (is_halt_c) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            pc            <= pc_next_c;
            bus.imem_addr <= pc_next_c;
            bus.imem_req  <= 1'b1;
            state         <= S_FETCH;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stub + memory responder, ISA-level model
// feeding a scoreboard queue, and a monitor checking every fetch and retire.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       retire;
  logic       halted;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .retire   (retire),
    .halted   (halted),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // ---------------- ALU stub ----------------
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return {7'd0, ($signed(a) < $signed(b))};
      4'h9: return a + b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 8'h00);
  // Non-branch opcodes get a data-dependent junk flag that must be ignored
  assign bus.alu_branch_taken = (bus.alu_opcode == 4'hB) ? (bus.alu_a == bus.alu_b) :
                                (bus.alu_opcode == 4'hC) ? (bus.alu_a != bus.alu_b) :
                                (bus.alu_a[0] ^ bus.alu_b[1]);

  // ---------------- counters / checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [256];
  int max_wait   = 0;
  bit fixed_wait = 1'b1;
  bit stray_en   = 1'b0;
  int wait_left  = 0;

  always @(negedge clk) begin
    if (bus.imem_req) begin
      if (wait_left == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = mem[bus.imem_addr];
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'($urandom);
        wait_left--;
      end
    end else begin
      wait_left      = fixed_wait ? max_wait : $urandom_range(max_wait, 0);
      bus.imem_valid = stray_en ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.imem_data  = 16'($urandom);
    end
  end

  // ---------------- debug select driver ----------------
  bit         dbg_hold = 1'b0;
  logic [1:0] dbg_fix  = 2'd0;

  always @(posedge clk) begin
    #1;
    dbg_sel = dbg_hold ? dbg_fix : 2'($urandom);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]      pc;
    logic [3:0]      op;
    logic [7:0]      a;
    logic [7:0]      b;
    bit              chk_ab;
    logic [3:0][7:0] regs;
    bit              halt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_pc;
  logic [7:0] m_r [4];
  bit         m_halted;

  function automatic int sx8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic run_model(input int steps);
    exp_t e;
    int   op, rd, a, b, res, nxt;
    m_pc = 8'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_halted = 1'b0;
    for (int s = 0; s < steps && !m_halted; s++) begin
      op       = int'(mem[m_pc][15:12]);
      e.pc     = m_pc;
      e.op     = 4'(op);
      e.chk_ab = 1'b1;
      e.halt   = 1'b0;
      nxt      = (int'(m_pc) + 1) % 256;
      a        = 0;
      b        = 0;
      if (op <= 5) begin
        rd = int'(mem[m_pc][11:10]);
        a  = int'(m_r[mem[m_pc][9:8]]);
        b  = int'(mem[m_pc][7:6] == 2'd0 ? m_r[0] : m_r[mem[m_pc][7:6]]);
        case (op)
          0: res = (a + b) % 256;
          1: res = (a - b + 256) % 256;
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          default: res = (sx8(a) < sx8(b)) ? 1 : 0;
        endcase
        m_r[rd] = 8'(res);
      end else if (op == 9) begin
        rd = int'(mem[m_pc][11:10]);
        a  = int'(m_r[mem[m_pc][9:8]]);
        b  = int'(mem[m_pc][7:0]);
        m_r[rd] = 8'((a + b) % 256);
      end else if (op == 11 || op == 12) begin
        a = int'(m_r[mem[m_pc][11:10]]);
        b = int'(m_r[mem[m_pc][9:8]]);
        if ((op == 11) == (a == b))
          nxt = (int'(m_pc) + 1 + sx8(int'(mem[m_pc][7:0])) + 256) % 256;
      end else if (op == 15) begin
        e.chk_ab = 1'b0;
        e.halt   = 1'b1;
        nxt      = int'(m_pc);
        m_halted = 1'b1;
      end else begin
        e.chk_ab = 1'b0;
      end
      e.a = 8'(a);
      e.b = 8'(b);
      for (int i = 0; i < 4; i++) e.regs[i] = m_r[i];
      sb.push_back(e);
      m_pc = 8'(nxt);
    end
  endtask

  // ---------------- monitor ----------------
  bit   mon_en    = 1'b0;
  bit   reg_chk   = 1'b0;
  bit   have_prev = 1'b0;
  int   cyc       = 0;
  int   acc_cyc   = 0;
  int   prev_ret  = 0;
  exp_t last;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && mon_en) begin
      if (reg_chk) begin
        reg_chk = 1'b0;
        chk("wb_reg", dbg_data, last.regs[dbg_sel]);
        chk("halted", halted, last.halt);
      end
      if (bus.imem_req && sb.size() > 0) begin
        chk("fetch_addr", bus.imem_addr, sb[0].pc);
        if (bus.imem_valid) acc_cyc = cyc;
      end
      if (retire) begin
        if (sb.size() == 0) begin
          chk("retire_unexpected", retire, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("alu_opcode", bus.alu_opcode, e.op);
          if (e.chk_ab) begin
            chk("alu_a", bus.alu_a, e.a);
            chk("alu_b", bus.alu_b, e.b);
          end
          chk("retire_latency", cyc - acc_cyc, 2);
          if (fixed_wait && have_prev) chk("retire_gap", cyc - prev_ret, 3 + max_wait);
          have_prev = 1'b1;
          prev_ret  = cyc;
          last      = e;
          reg_chk   = 1'b1;
        end
      end
    end
  end

  // ---------------- test helpers ----------------
  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 2'(rd), 2'(rs), 2'(rt), 6'd0};
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int f1, input int f2, input int imm);
    return {4'(op), 2'(f1), 2'(f2), 8'(imm)};
  endfunction

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic release_and_check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", bus.imem_req, 1'b0);
    @(negedge clk);
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 8'h00);
  endtask

  task automatic run_prog(input int steps);
    bit done = 1'b0;
    int budget;
    rst_n = 1'b0;
    dbg_hold = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_alu_a", bus.alu_a, 8'h00);
    chk("rst_opcode", bus.alu_opcode, 4'h0);
    chk("rst_halted", halted, 1'b0);
    sb.delete();
    run_model(steps);
    reg_chk   = 1'b0;
    have_prev = 1'b0;
    mon_en    = 1'b1;
    release_and_check();
    budget = steps * (6 + max_wait) + 40;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !reg_chk) done = 1'b1;
    end
    chk("drain", sb.size(), 0);
    mon_en = 1'b0;
    if (m_halted && done) begin
      repeat (4) begin
        @(negedge clk);
        chk("halt_req", bus.imem_req, 1'b0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc", bus.imem_addr, m_pc);
      end
      for (int i = 0; i < 4; i++) begin
        dbg_fix  = 2'(i);
        dbg_hold = 1'b1;
        @(posedge clk);
        #2;
        chk("final_reg", dbg_data, m_r[i]);
      end
      dbg_hold = 1'b0;
    end
    rst_n = 1'b0;
  endtask

  task automatic reset_mid_execute();
    bit seen = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    mon_en = 1'b0;
    fill_mem(16'hF000);
    mem[0] = enc_i(9, 1, 0, 8'h55);
    max_wait = 0; fixed_wait = 1'b1; stray_en = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (retire) seen = 1'b1;
    end
    chk("midexec_retire_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midexec_retire", retire, 1'b0);
    chk("midexec_req", bus.imem_req, 1'b0);
    chk("midexec_addr", bus.imem_addr, 8'h00);
    dbg_fix  = 2'd1;
    dbg_hold = 1'b1;
    @(posedge clk);
    #2;
    chk("midexec_r1", dbg_data, 8'h00);
    dbg_hold = 1'b0;
    release_and_check();
    rst_n = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op_tab [17] = '{0, 1, 2, 3, 4, 5, 9, 9, 11, 12, 6, 7, 8, 10, 13, 14, 15};
    logic [15:0] w;

    // Dependent ADDI/ADDI/SUB then HALT, zero-wait memory
    fill_mem(16'hF000);
    mem[0] = enc_i(9, 1, 0, 8'h05);
    mem[1] = enc_i(9, 2, 0, 8'h03);
    mem[2] = enc_r(1, 3, 2, 1);
    mem[3] = 16'hF000;
    max_wait = 0; fixed_wait = 1'b1; stray_en = 1'b0;
    run_prog(10);

    // Same program with 3 wait cycles per fetch and stray valids elsewhere
    max_wait = 3; fixed_wait = 1'b1; stray_en = 1'b1;
    run_prog(10);

    // Branches: BEQ taken backwards, BNE not taken
    fill_mem(16'hF000);
    mem[0]     = enc_i(9, 1, 0, 8'h07);
    mem[1]     = enc_i(9, 2, 0, 8'h07);
    mem[2]     = enc_i(11, 0, 0, 8'h0D);
    mem[8'h10] = enc_i(11, 1, 2, 8'hFE);
    mem[8'h0F] = enc_i(12, 1, 2, 8'h40);
    max_wait = 0; fixed_wait = 1'b1; stray_en = 1'b1;
    run_prog(9);

    // PC wrap at 0xFF, reached by a negative branch from 0x00
    fill_mem(16'hF000);
    mem[0]     = enc_i(11, 0, 0, 8'hFE);
    mem[8'hFF] = enc_i(9, 0, 0, 8'h01);
    run_prog(5);

    // NOPs then HALT at 0x04
    fill_mem(16'h6000);
    mem[4] = 16'hF000;
    max_wait = 2; fixed_wait = 1'b0; stray_en = 1'b1;
    run_prog(10);

    reset_mid_execute();

    // Random programs with random memory timing
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        w[15:12] = 4'(op_tab[$urandom_range(16, 0)]);
        mem[i] = w;
      end
      max_wait   = $urandom_range(3, 0);
      fixed_wait = 1'($urandom_range(1, 0));
      stray_en   = 1'b1;
      run_prog(50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
